// File: rtl/iram_controller_if.sv
// Bundle between the line-fill controller, the fetch core (miss request/word return)
// and the instruction memory (read strobe/address/data).
interface iram_controller_if #(
    parameter int PC_SIZE    = 32,
    parameter int MEM_WORD   = 32,
    parameter int LINE_WORDS = 4
);
    localparam int OFF_W = $clog2(LINE_WORDS);

    logic                i_miss;
    logic [PC_SIZE-1:0]  iram_address;
    logic [MEM_WORD-1:0] imem_word;
    logic                word_ready;
    logic [OFF_W-1:0]    word_offset;
    logic                line_done;
    logic                busy;
    logic                mem_re;
    logic [PC_SIZE-1:0]  mem_addr;
    logic [MEM_WORD-1:0] mem_rdata;

    modport slave (
        input  i_miss, iram_address, mem_rdata,
        output imem_word, word_ready, word_offset, line_done, busy, mem_re, mem_addr
    );

    modport master (
        output i_miss, iram_address, mem_rdata,
        input  imem_word, word_ready, word_offset, line_done, busy, mem_re, mem_addr
    );
endinterface

// File: rtl/iram_controller.sv
// Instruction line-fill controller: fetches one cache line word by word,
// critical word first with wrap-around, one memory request outstanding at a time.
module iram_controller #(
    parameter int PC_SIZE     = 32,
    parameter int MEM_WORD    = 32,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = 2
) (
    input logic clk,
    input logic rst,
    iram_controller_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [PC_SIZE-1:0] LOW_MASK = PC_SIZE'((1 << (OFF_W + 2)) - 1);
    localparam logic [OFF_W-1:0]   LAST_CNT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DELIVER, DONE} state_t;

    state_t              state, state_nxt;
    logic [PC_SIZE-1:0]  base;
    logic [OFF_W-1:0]    crit, cnt, offset;
    logic [LAT_W-1:0]    lat_cnt;
    logic [MEM_WORD-1:0] word;
    logic                wait_last;

    assign offset    = crit + cnt;
    assign wait_last = (lat_cnt == LAT_W'(MEM_LATENCY - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Dropping i_miss anywhere in the fill abandons it; DONE waits for the release.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_miss) state_nxt = REQ;
            REQ:     state_nxt = bus.i_miss ? WAIT : IDLE;
            WAIT:    if (!bus.i_miss) state_nxt = IDLE;
                     else if (wait_last) state_nxt = DELIVER;
            DELIVER: if (!bus.i_miss) state_nxt = IDLE;
                     else if (cnt == LAST_CNT) state_nxt = DONE;
                     else state_nxt = REQ;
            DONE:    if (!bus.i_miss) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base    <= '0;
            crit    <= '0;
            cnt     <= '0;
            lat_cnt <= '0;
            word    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.i_miss) begin
                    base <= bus.iram_address & ~LOW_MASK;
                    crit <= bus.iram_address[OFF_W+1:2];
                    cnt  <= '0;
                end
                REQ:     lat_cnt <= '0;
                WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (wait_last && bus.i_miss) word <= bus.mem_rdata;
                end
                DELIVER: if (bus.i_miss) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_re      = (state == REQ) && bus.i_miss;
        bus.mem_addr    = bus.mem_re ? (base | (PC_SIZE'(offset) << 2)) : '0;
        bus.word_ready  = (state == DELIVER) && bus.i_miss;
        bus.word_offset = (state == DELIVER) ? offset : '0;
        bus.line_done   = bus.word_ready && (cnt == LAST_CNT);
        bus.busy        = (state != IDLE);
        bus.imem_word   = word;
    end
endmodule
